// File: rtl/inst_rom_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// inst_rom_arbiter_pkg
// Shared constants for the instruction-ROM arbiter: FSM state encodings,
// requester ids, default bus widths and a saturating counter helper.
// ---------------------------------------------------------------------------
package inst_rom_arbiter_pkg;

    // FSM state encodings
    localparam logic [0:0] ArbStIf  = 1'b0;
    localparam logic [0:0] ArbStDbg = 1'b1;

    // Requester ids (also the encoding of the round-robin last-winner flag)
    localparam logic ArbIdIf  = 1'b0;
    localparam logic ArbIdDbg = 1'b1;

    // Default instruction bus geometry
    localparam int InstAddrBus    = 32;
    localparam int InstBus        = 32;
    localparam int InstMemNumLog2 = 17;

    // Width of the DBG starvation counter (MAX_WAIT is limited to 1..255)
    localparam int WaitCntW = 8;

    // Increment that sticks at the given ceiling
    function automatic logic [WaitCntW-1:0] sat_inc(input logic [WaitCntW-1:0] cnt,
                                                    input logic [WaitCntW-1:0] ceil);
        return (cnt >= ceil) ? ceil : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/inst_arb_addr_chk.sv
// ---------------------------------------------------------------------------
// inst_arb_addr_chk
// Combinational legality check of a requester byte address.
//   i_addr : byte address presented by a requester
//   o_bad  : 1 when the address is misaligned (addr[1:0] != 0) or any bit
//            above the ROM word-address field [MEM_LOG2+1:2] is set
// ---------------------------------------------------------------------------
module inst_arb_addr_chk
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W   = InstAddrBus,
    parameter int MEM_LOG2 = InstMemNumLog2
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_bad
);

    localparam int HiLsb = MEM_LOG2 + 2;

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned = |i_addr[1:0];

    // When the ROM spans the whole address space there is nothing above it.
    generate
        if (HiLsb < ADDR_W) begin : g_range
            assign w_out_of_range = |i_addr[ADDR_W-1:HiLsb];
        end else begin : g_full
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign o_bad = w_misaligned | w_out_of_range;

endmodule

// File: rtl/inst_rom_arbiter.sv
// ---------------------------------------------------------------------------
// inst_rom_arbiter
// Shares the instruction ROM read port between the fetch stage (IF) and the
// debug/boot-inspection port (DBG). The winner's address is driven onto the
// ROM in the grant cycle; ROM data is registered, giving 1-cycle latency.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   if_req/if_addr                fetch request and byte address
//   if_gnt/if_rvalid/if_err       fetch grant (comb), response valid, error
//   dbg_req/dbg_lock/dbg_addr     debug request, burst lock, byte address
//   dbg_gnt/dbg_rvalid/dbg_err    debug grant (comb), response valid, error
//   rdata                         shared response data register
//   rom_ce/rom_addr/rom_inst      ROM chip enable, address (comb), read data
//   stallreq_if                   fetch blocked, to pipeline controller
//
// Build option INST_ARB_RR_EN: round-robin between IF and DBG in S_IF
// instead of fixed IF priority with a DBG starvation guard.
// ---------------------------------------------------------------------------
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W   = InstAddrBus,
    parameter int DATA_W   = InstBus,
    parameter int MEM_LOG2 = InstMemNumLog2,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic              if_err,
    input  logic              dbg_req,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic              dbg_err,
    output logic [DATA_W-1:0] rdata,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic              stallreq_if
);

    logic              w_if_bad;
    logic              w_dbg_bad;
    logic              w_if_gnt;
    logic              w_dbg_gnt;
    logic              w_sel_bad;
    logic [0:0]        w_state_nxt;
    logic [0:0]        r_state;
    logic              r_if_rvalid;
    logic              r_dbg_rvalid;
    logic              r_if_err;
    logic              r_dbg_err;
    logic [DATA_W-1:0] r_rdata;

    inst_arb_addr_chk #(.ADDR_W(ADDR_W), .MEM_LOG2(MEM_LOG2)) u_if_chk (
        .i_addr (if_addr),
        .o_bad  (w_if_bad)
    );

    inst_arb_addr_chk #(.ADDR_W(ADDR_W), .MEM_LOG2(MEM_LOG2)) u_dbg_chk (
        .i_addr (dbg_addr),
        .o_bad  (w_dbg_bad)
    );

`ifdef INST_ARB_RR_EN
    logic r_last_winner;
`else
    localparam logic [WaitCntW-1:0] MaxWaitC = WaitCntW'(MAX_WAIT);
    logic [WaitCntW-1:0] r_wait_cnt;
    logic                w_force_dbg;

    assign w_force_dbg = (r_wait_cnt == MaxWaitC);
`endif

    // Grant decision
    always_comb begin
        w_if_gnt  = 1'b0;
        w_dbg_gnt = 1'b0;
        if (r_state == ArbStDbg) begin
            w_dbg_gnt = dbg_req;
        end else begin
`ifdef INST_ARB_RR_EN
            // On conflict, the requester that did not win last time goes.
            w_if_gnt  = if_req  && (!dbg_req || (r_last_winner == ArbIdDbg));
            w_dbg_gnt = dbg_req && (!if_req  || (r_last_winner == ArbIdIf));
`else
            w_if_gnt  = if_req  && !w_force_dbg;
            w_dbg_gnt = dbg_req && (!if_req || w_force_dbg);
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ArbStDbg) begin
            if (!dbg_req || !dbg_lock) w_state_nxt = ArbStIf;
        end else if (w_dbg_gnt && dbg_lock) begin
            w_state_nxt = ArbStDbg;
        end
    end

    assign w_sel_bad = w_if_gnt ? w_if_bad : w_dbg_bad;

    // Combinational outputs are forced low while reset is held.
    assign if_gnt      = rst & w_if_gnt;
    assign dbg_gnt     = rst & w_dbg_gnt;
    assign stallreq_if = rst & if_req & ~w_if_gnt;
    assign rom_ce      = rst & ((w_if_gnt & ~w_if_bad) | (w_dbg_gnt & ~w_dbg_bad));

    always_comb begin
        rom_addr = '0;
        if (rst) begin
            if (w_if_gnt)       rom_addr = if_addr;
            else if (w_dbg_gnt) rom_addr = dbg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ArbStIf;
            r_if_rvalid  <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_if_err     <= 1'b0;
            r_dbg_err    <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_if_rvalid  <= w_if_gnt;
            r_dbg_rvalid <= w_dbg_gnt;
            r_if_err     <= w_if_gnt & w_if_bad;
            r_dbg_err    <= w_dbg_gnt & w_dbg_bad;
            // A rejected access returns zero data; idle cycles hold rdata.
            if (w_if_gnt || w_dbg_gnt) begin
                r_rdata <= w_sel_bad ? '0 : rom_inst;
            end
        end
    end

`ifdef INST_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_winner <= ArbIdIf;
        end else if (w_if_gnt || w_dbg_gnt) begin
            r_last_winner <= w_dbg_gnt ? ArbIdDbg : ArbIdIf;
        end
    end
`else
    // DBG starvation counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (w_dbg_gnt || !dbg_req) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= sat_inc(r_wait_cnt, MaxWaitC);
        end
    end
`endif

    assign if_rvalid  = r_if_rvalid;
    assign dbg_rvalid = r_dbg_rvalid;
    assign if_err     = r_if_err;
    assign dbg_err    = r_dbg_err;
    assign rdata      = r_rdata;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_arbiter
// Directed bench for inst_rom_arbiter. Each stimulus cycle checks the
// combinational grant outputs and queues the expected response; a monitor
// on the falling edge pops the queue whenever a response is presented.
// ---------------------------------------------------------------------------
module tb_inst_rom_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 17;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid, if_err;
    logic          dbg_req = 1'b0;
    logic          dbg_lock = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic          dbg_gnt, dbg_rvalid, dbg_err;
    logic [DW-1:0] rdata;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_inst;
    logic          stallreq_if;

    always #5 clk = ~clk;

    inst_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LOG2(ML), .MAX_WAIT(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_err      (if_err),
        .dbg_req     (dbg_req),
        .dbg_lock    (dbg_lock),
        .dbg_addr    (dbg_addr),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_err     (dbg_err),
        .rdata       (rdata),
        .rom_ce      (rom_ce),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst),
        .stallreq_if (stallreq_if)
    );

    // Small ROM model: 16 words, combinational read
    logic [DW-1:0] rom_mem [0:15];
    assign rom_inst = rom_mem[rom_addr[5:2]];

    typedef struct packed {
        logic          dbg;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_r;
    int   n_err = 0;
    int   n_chk = 0;

    task automatic chk(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [AW-1:0] a);
        logic [AW-1:0] hi;
        hi = a >> (ML + 2);
        return (a[1:0] != 2'b00) || (hi != '0);
    endfunction

    // Response monitor
    always @(negedge clk) begin
        if (rst && (if_rvalid || dbg_rvalid)) begin
            chk("mon", "rvalid_both", 32'(if_rvalid & dbg_rvalid), 32'd0);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL mon.unexpected_rsp: got if_rvalid=%0b dbg_rvalid=%0b with empty queue",
                         if_rvalid, dbg_rvalid);
            end else begin
                mon_r = exp_q.pop_front();
                chk("mon", "rsp_is_dbg", 32'(dbg_rvalid), 32'(mon_r.dbg));
                chk("mon", "rsp_err", 32'(dbg_rvalid ? dbg_err : if_err), 32'(mon_r.err));
                chk("mon", "rdata", rdata, mon_r.data);
            end
        end
    end

    // One stimulus cycle: drive after the edge, check combinational outputs
    // mid-cycle, queue the expected response of any grant.
    task automatic step(input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dl, input logic [AW-1:0] da,
                        input logic eig, input logic edg, input logic est,
                        input string tag);
        logic          ece;
        logic [AW-1:0] ea;
        @(posedge clk);
        #1;
        if_req   = ir;
        if_addr  = ia;
        dbg_req  = dr;
        dbg_lock = dl;
        dbg_addr = da;
        #2;
        ece = (eig && !addr_bad(ia)) || (edg && !addr_bad(da));
        ea  = eig ? ia : (edg ? da : '0);
        chk(tag, "if_gnt", 32'(if_gnt), 32'(eig));
        chk(tag, "dbg_gnt", 32'(dbg_gnt), 32'(edg));
        chk(tag, "stallreq_if", 32'(stallreq_if), 32'(est));
        chk(tag, "rom_ce", 32'(rom_ce), 32'(ece));
        chk(tag, "rom_addr", rom_addr, ea);
        if (eig) exp_q.push_back('{1'b0, addr_bad(ia), addr_bad(ia) ? '0 : rom_mem[ia[5:2]]});
        if (edg) exp_q.push_back('{1'b1, addr_bad(da), addr_bad(da) ? '0 : rom_mem[da[5:2]]});
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic       e;

        for (int i = 0; i < 16; i++) rom_mem[i] = 32'hA000_0000 + 32'(i);
        rom_mem[0] = 32'h3401_0020;
        rom_mem[1] = 32'h2021_0002;
        rom_mem[2] = 32'h3421_1100;

        // Reset: requests present but all outputs held at 0
        if_req  = 1'b1;
        dbg_req = 1'b1;
        #12;
        chk("rst", "if_gnt", 32'(if_gnt), 32'd0);
        chk("rst", "dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst", "stallreq_if", 32'(stallreq_if), 32'd0);
        chk("rst", "rom_ce", 32'(rom_ce), 32'd0);
        chk("rst", "if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst", "dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst", "rdata", rdata, 32'd0);
        if_req  = 1'b0;
        dbg_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        // IF only: back-to-back fetches
        step(1'b1, 32'h0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "if0");
        step(1'b1, 32'h4, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "if1");
        step(1'b1, 32'h8, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "if2");
        idle("idle0");

        // Continuous conflict: bit i set = DBG wins cycle i
`ifdef INST_ARB_RR_EN
        pat = 8'b0101_0101;
`else
        pat = 8'b1000_1000;
`endif
        for (int i = 0; i < 8; i++) begin
            e = pat[i];
            step(1'b1, 32'hC, 1'b1, 1'b0, 32'h10, !e, e, e, $sformatf("cf%0d", i));
        end
        idle("idle1");

        // Locked DBG burst of 5, IF arrives one cycle later
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 1'b0, 1'b1, 1'b0, "lk0");
        for (int i = 1; i < 5; i++)
            step(1'b1, 32'h18, 1'b1, 1'b1, 32'h14 + 32'(4 * i), 1'b0, 1'b1, 1'b1,
                 $sformatf("lk%0d", i));
        step(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "lk5");
        step(1'b1, 32'h1C, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, "lk6");
        idle("idle2");

        // Bad addresses: granted, no ROM access, error response with zero data
        step(1'b1, 32'h2, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "er0");
        step(1'b1, 32'h0008_0000, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "er1");
        step(1'b1, 32'h4, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "er2");
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h1, 1'b0, 1'b1, 1'b0, "er3");
        idle("idle3");

        // Reset in the middle of a locked burst with a response pending
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, "rb0");
        @(posedge clk);
        #1;
        if_req   = 1'b1;
        if_addr  = 32'h24;
        dbg_addr = 32'h28;
        #2;
        chk("rb1", "dbg_gnt", 32'(dbg_gnt), 32'd1);
        chk("rb1", "if_gnt", 32'(if_gnt), 32'd0);
        chk("rb1", "stallreq_if", 32'(stallreq_if), 32'd1);
        @(posedge clk);
        #1;
        chk("rb2", "dbg_rvalid_pending", 32'(dbg_rvalid), 32'd1);
        rst = 1'b0;
        #1;
        chk("rb2", "dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rb2", "if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rb2", "dbg_err", 32'(dbg_err), 32'd0);
        chk("rb2", "rdata", rdata, 32'd0);
        chk("rb2", "dbg_gnt", 32'(dbg_gnt), 32'd0);
        if_req   = 1'b0;
        dbg_req  = 1'b0;
        dbg_lock = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
`ifdef INST_ARB_RR_EN
        step(1'b1, 32'h24, 1'b1, 1'b1, 32'h28, 1'b0, 1'b1, 1'b0, "ra0");
`else
        step(1'b1, 32'h24, 1'b1, 1'b1, 32'h28, 1'b1, 1'b0, 1'b0, "ra0");
`endif
        idle("idle4");
        idle("idle5");

        chk("end", "queue_left", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
